// File: rtl/stopwatch_core.sv
// MM:SS stopwatch driven by synchronized, edge-detected 1Hz/2Hz strobes from the divider.
// Optional lap hold display freeze: define LAP_HOLD_EN.
module stopwatch_core #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WRAP    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz_in,
  input  logic       clk_2hz_in,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
`ifdef LAP_HOLD_EN
  input  logic       lap_btn,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blink
);

  typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } count_t;

  localparam logic [3:0] WRAP_T = 4'((MIN_WRAP - 1) / 10);
  localparam logic [3:0] WRAP_O = 4'((MIN_WRAP - 1) % 10);

  // Edge-detected inputs occupy the low bits; adj/sel levels sit above them.
`ifdef LAP_HOLD_EN
  localparam int NEDGE = 4;
  logic [NEDGE-1:0] edge_raw;
  assign edge_raw = {lap_btn, pause_btn, clk_2hz_in, clk_1hz_in};
`else
  localparam int NEDGE = 3;
  logic [NEDGE-1:0] edge_raw;
  assign edge_raw = {pause_btn, clk_2hz_in, clk_1hz_in};
`endif
  localparam int NIN = NEDGE + 2;

  logic [NIN-1:0]   in_raw;
  logic [NIN-1:0]   sync_q [SYNC_STAGES];
  logic [NIN-1:0]   in_s;
  logic [NEDGE-1:0] prev_q;
  logic [NEDGE-1:0] pulse_q;

  assign in_raw = {sel, adj, edge_raw};
  assign in_s   = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync_q[0] <= in_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q  <= in_s[NEDGE-1:0];
      pulse_q <= in_s[NEDGE-1:0] & ~prev_q;
    end
  end

  logic sec_p, adj_p, pau_p, clk2_s, adj_s, sel_s;
  assign sec_p  = pulse_q[0];
  assign adj_p  = pulse_q[1];
  assign pau_p  = pulse_q[2];
  assign clk2_s = in_s[1];
  assign adj_s  = in_s[NEDGE];
  assign sel_s  = in_s[NEDGE+1];

  function automatic count_t inc_min(input count_t t);
    count_t r;
    r = t;
    if (t.mt == WRAP_T && t.mo == WRAP_O) begin
      r.mt = 4'd0;
      r.mo = 4'd0;
    end else if (t.mo == 4'd9) begin
      r.mo = 4'd0;
      r.mt = t.mt + 4'd1;
    end else begin
      r.mo = t.mo + 4'd1;
    end
    return r;
  endfunction

  // Seconds field alone, 59 -> 00 without touching minutes.
  function automatic count_t inc_sec(input count_t t);
    count_t r;
    r = t;
    if (t.so == 4'd9) begin
      r.so = 4'd0;
      r.st = (t.st == 4'd5) ? 4'd0 : t.st + 4'd1;
    end else begin
      r.so = t.so + 4'd1;
    end
    return r;
  endfunction

  state_t state, state_nx;
  count_t cnt_q, cnt_nx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    unique case (state)
      PAUSED: begin
        if (adj_s)      state_nx = ADJUST;
        else if (pau_p) state_nx = RUN;
      end
      RUN: begin
        if (adj_s) begin
          state_nx = ADJUST;
        end else begin
          if (sec_p) begin
            cnt_nx = inc_sec(cnt_q);
            if (cnt_q.st == 4'd5 && cnt_q.so == 4'd9) cnt_nx = inc_min(cnt_nx);
          end
          if (pau_p) state_nx = PAUSED;
        end
      end
      ADJUST: begin
        if (adj_p) cnt_nx = sel_s ? inc_min(cnt_q) : inc_sec(cnt_q);
        if (!adj_s) state_nx = PAUSED;
      end
      default: state_nx = PAUSED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PAUSED;
      cnt_q <= '0;
      blink <= 1'b0;
    end else begin
      state <= state_nx;
      cnt_q <= cnt_nx;
      blink <= (state_nx == ADJUST) && clk2_s;
    end
  end

  assign running = (state == RUN);

  count_t disp;
`ifdef LAP_HOLD_EN
  logic   lap_p;
  logic   hold_q;
  count_t snap_q;
  assign lap_p = pulse_q[3];

  // Any exit from RUN drops the hold in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else if (state_nx != RUN) begin
      hold_q <= 1'b0;
    end else if (state == RUN && lap_p) begin
      hold_q <= ~hold_q;
      if (!hold_q) snap_q <= cnt_q;
    end
  end

  assign disp = hold_q ? snap_q : cnt_q;
`else
  assign disp = cnt_q;
`endif

  assign min_tens = disp.mt;
  assign min_ones = disp.mo;
  assign sec_tens = disp.st;
  assign sec_ones = disp.so;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: vector table, directed corner sequences,
// and randomized actions checked against a total-seconds reference model.
module tb_stopwatch_core;

  localparam int SS = 2;
  localparam int MW = 60;

  logic clk = 1'b0;
  logic rst, c1, c2, pb, adj, sel;
`ifdef LAP_HOLD_EN
  logic lap;
`endif
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, blink;

  stopwatch_core #(.SYNC_STAGES(SS), .MIN_WRAP(MW)) dut (
    .clk(clk), .rst(rst), .clk_1hz_in(c1), .clk_2hz_in(c2),
    .pause_btn(pb), .adj(adj), .sel(sel),
`ifdef LAP_HOLD_EN
    .lap_btn(lap),
`endif
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef enum int {A_1HZ, A_2HZ, A_PAUSE, A_ADJ_ON, A_ADJ_OFF, A_SEL0, A_SEL1, A_LAP} act_t;
  typedef struct {
    act_t act;
    int   reps;
    int   exp_min;
    int   exp_sec;
    logic exp_run;
  } vec_t;

  localparam int M_PAUSED = 0, M_RUN = 1, M_ADJ = 2;
  int n_cmp = 0, n_err = 0;
  int m_min, m_sec, m_mode, m_adj, m_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int m, input int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check_disp(input string name, input int m, input int s, input logic run);
    check({name, " time"}, {16'd0, min_tens, min_ones, sec_tens, sec_ones}, {16'd0, bcd(m, s)});
    check({name, " running"}, {31'd0, running}, {31'd0, run});
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_mode = M_PAUSED; m_adj = 0; m_sel = 0;
  endtask

  task automatic model_update(input act_t a);
    int t;
    case (a)
      A_1HZ: if (m_mode == M_RUN) begin
        t = (m_min * 60 + m_sec + 1) % (MW * 60);
        m_min = t / 60;
        m_sec = t % 60;
      end
      A_2HZ: if (m_mode == M_ADJ) begin
        if (m_sel == 1) m_min = (m_min + 1) % MW;
        else            m_sec = (m_sec + 1) % 60;
      end
      A_PAUSE: if (m_mode == M_RUN) m_mode = M_PAUSED;
               else if (m_mode == M_PAUSED) m_mode = M_RUN;
      A_ADJ_ON:  begin m_adj = 1; m_mode = M_ADJ; end
      A_ADJ_OFF: begin m_adj = 0; if (m_mode == M_ADJ) m_mode = M_PAUSED; end
      A_SEL0: m_sel = 0;
      A_SEL1: m_sel = 1;
      default: ;
    endcase
  endtask

  task automatic set_edge(input act_t a, input logic v);
    case (a)
      A_1HZ:   c1 = v;
      A_2HZ:   c2 = v;
      A_PAUSE: pb = v;
`ifdef LAP_HOLD_EN
      A_LAP:   lap = v;
`endif
      default: ;
    endcase
  endtask

  task automatic do_action(input act_t a);
    case (a)
      A_ADJ_ON:  begin adj = 1'b1; wait_n(6); end
      A_ADJ_OFF: begin adj = 1'b0; wait_n(6); end
      A_SEL0:    begin sel = 1'b0; wait_n(6); end
      A_SEL1:    begin sel = 1'b1; wait_n(6); end
      default: begin
        set_edge(a, 1'b1);
        wait_n(4);
        if (a == A_2HZ)
          check("blink while 2hz high", {31'd0, blink}, {31'd0, (m_mode == M_ADJ)});
        set_edge(a, 1'b0);
        wait_n(4);
      end
    endcase
    model_update(a);
  endtask

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{A_1HZ,     3,  0,  0, 1'b0};
    vecs[1]  = '{A_PAUSE,   1,  0,  0, 1'b1};
    vecs[2]  = '{A_1HZ,    75,  1, 15, 1'b1};
    vecs[3]  = '{A_PAUSE,   1,  1, 15, 1'b0};
    vecs[4]  = '{A_1HZ,     2,  1, 15, 1'b0};
    vecs[5]  = '{A_ADJ_ON,  1,  1, 15, 1'b0};
    vecs[6]  = '{A_SEL1,    1,  1, 15, 1'b0};
    vecs[7]  = '{A_2HZ,    58, 59, 15, 1'b0};
    vecs[8]  = '{A_SEL0,    1, 59, 15, 1'b0};
    vecs[9]  = '{A_2HZ,    44, 59, 59, 1'b0};
    vecs[10] = '{A_ADJ_OFF, 1, 59, 59, 1'b0};
    vecs[11] = '{A_PAUSE,   1, 59, 59, 1'b1};
    vecs[12] = '{A_1HZ,     1,  0,  0, 1'b1};
    vecs[13] = '{A_1HZ,     9,  0,  9, 1'b1};

    rst = 1'b1; c1 = 0; c2 = 0; pb = 0; adj = 0; sel = 0;
`ifdef LAP_HOLD_EN
    lap = 0;
`endif
    model_reset();
    wait_n(3);
    check_disp("reset", 0, 0, 1'b0);
    check("reset blink", {31'd0, blink}, 32'd0);
    rst = 1'b0;
    wait_n(2);

    foreach (vecs[i]) begin
      repeat (vecs[i].reps) do_action(vecs[i].act);
      check_disp($sformatf("vec%0d", i), vecs[i].exp_min, vecs[i].exp_sec, vecs[i].exp_run);
    end

    // 1Hz and pause edges in the same clock while RUN at 00:09.
    c1 = 1'b1; pb = 1'b1; wait_n(4);
    c1 = 1'b0; pb = 1'b0; wait_n(4);
    m_sec = 10; m_mode = M_PAUSED;
    check_disp("sec+pause same clk", 0, 10, 1'b0);

    // Input rise to digit update takes SYNC_STAGES+2 clocks.
    do_action(A_PAUSE);
    c1 = 1'b1;
    wait_n(SS + 1);
    check_disp("latency before", 0, 10, 1'b1);
    wait_n(1);
    check_disp("latency after", 0, 11, 1'b1);
    c1 = 1'b0; wait_n(4);
    model_update(A_1HZ);

    // 1Hz edge coinciding with adj rise: no increment, enter ADJUST.
    c1 = 1'b1; adj = 1'b1; wait_n(4);
    c1 = 1'b0; wait_n(4);
    m_adj = 1; m_mode = M_ADJ;
    check_disp("sec+adj same clk", 0, 11, 1'b0);

    repeat (47) do_action(A_2HZ);
    check_disp("preload 00:58", 0, 58, 1'b0);
    for (int k = 0; k < 3; k++) begin
      c2 = 1'b1; wait_n(SS + 2);
      check($sformatf("blink high %0d", k), {31'd0, blink}, 32'd1);
      c2 = 1'b0; wait_n(SS + 2);
      check($sformatf("blink low %0d", k), {31'd0, blink}, 32'd0);
      model_update(A_2HZ);
    end
    check_disp("adjust sec wrap no carry", 0, 1, 1'b0);
    do_action(A_PAUSE);
    check_disp("pause ignored in adjust", 0, 1, 1'b0);
    do_action(A_ADJ_OFF);
    check_disp("adj off paused", 0, 1, 1'b0);
    c2 = 1'b1; wait_n(SS + 2);
    check("blink outside adjust", {31'd0, blink}, 32'd0);
    c2 = 1'b0; wait_n(4);

    do_action(A_ADJ_ON);
    do_action(A_SEL1);
    repeat (59) do_action(A_2HZ);
    check_disp("adjust min 59", 59, 1, 1'b0);
    do_action(A_2HZ);
    check_disp("adjust min wrap", 0, 1, 1'b0);
    do_action(A_ADJ_OFF);
    do_action(A_SEL0);

    // Asynchronous reset mid-count clears before the next clock edge.
    do_action(A_PAUSE);
    repeat (3) do_action(A_1HZ);
    check_disp("before rst", 0, 4, 1'b1);
    #2 rst = 1'b1;
    #1 check_disp("async rst", 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_n(2);

    for (int i = 0; i < 150; i++) begin
      act_t a;
      int r;
      r = $urandom_range(0, 99);
      if (r < 35)      a = A_1HZ;
      else if (r < 60) a = A_2HZ;
      else if (r < 75) a = A_PAUSE;
      else if (r < 90) a = (m_adj != 0) ? A_ADJ_OFF : A_ADJ_ON;
      else             a = (m_sel != 0) ? A_SEL0 : A_SEL1;
      do_action(a);
      check_disp($sformatf("rand%0d", i), m_min, m_sec, (m_mode == M_RUN));
      check($sformatf("rand%0d blink", i), {31'd0, blink}, 32'd0);
    end

`ifdef LAP_HOLD_EN
    adj = 1'b0; sel = 1'b0;
    rst = 1'b1; wait_n(2); rst = 1'b0; wait_n(2);
    model_reset();
    do_action(A_PAUSE);
    repeat (5) do_action(A_1HZ);
    check_disp("lap pre", 0, 5, 1'b1);
    do_action(A_LAP);
    repeat (3) do_action(A_1HZ);
    check_disp("lap held", 0, 5, 1'b1);
    do_action(A_LAP);
    check_disp("lap released", 0, 8, 1'b1);
    do_action(A_LAP);
    do_action(A_PAUSE);
    check_disp("lap cleared by pause", 0, 8, 1'b0);
    do_action(A_PAUSE);
    do_action(A_1HZ);
    check_disp("lap stays live", 0, 9, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
